// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared widths and the rotate datapath function for shift_arbiter
package shift_arb_pkg;
   localparam int DATA_W = 8;
   localparam int AMT_W  = 3;
   function automatic logic [DATA_W-1:0] rotate(input logic [DATA_W-1:0] d, input logic [AMT_W-1:0] amt, input logic left);
      logic [AMT_W-1:0]  a;
      logic [DATA_W-1:0] s4, s2;
      a  = left ? AMT_W'(3'd0 - amt) : amt;
      s4 = a[2] ? {d[3:0], d[7:4]} : d;
      s2 = a[1] ? {s4[1:0], s4[7:2]} : s4;
      return a[0] ? {s2[0], s2[7:1]} : s2;
   endfunction
endpackage

// File: rtl/shift_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick starting after last_id; one-hot grant gated by accept
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    last_id,
   input  logic               accept,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id
);
   logic found;
   // search last_id+1, last_id+2, ... wrapping; first valid requester wins
   always_comb begin
      found  = 1'b0;
      gnt_id = last_id;
      gnt    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[(int'(last_id) + k) % NUM_REQ]) begin
            found  = 1'b1;
            gnt_id = ID_W'((int'(last_id) + k) % NUM_REQ);
         end
      end
      if (found && accept) gnt[gnt_id] = 1'b1;
   end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin shared 8-bit rotator with registered output; SHIFT_ARB_DIR_EN adds rotate-left
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   input  logic [AMT_W*NUM_REQ-1:0]  req_amt,
`ifdef SHIFT_ARB_DIR_EN
   input  logic [NUM_REQ-1:0]        req_dir,
   output logic                      out_dir,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [ID_W-1:0]           out_id
);
   logic                 accept, xfer, sel_dir;
   logic [NUM_REQ-1:0]   gnt;
   logic [ID_W-1:0]      gnt_id, last_id_q, last_id_d, out_id_q, out_id_d;
   logic                 out_valid_q, out_valid_d;
   logic [DATA_W-1:0]    out_data_q, out_data_d;
   assign accept = !out_valid_q || out_ready;
   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req_valid (req_valid),
      .last_id   (last_id_q),
      .accept    (accept),
      .gnt       (gnt),
      .gnt_id    (gnt_id)
   );
   assign req_ready = rst ? '0 : gnt;
   assign xfer      = |req_ready;
`ifdef SHIFT_ARB_DIR_EN
   logic out_dir_q, out_dir_d;
   assign sel_dir   = req_dir[gnt_id];
   assign out_dir_d = xfer ? sel_dir : out_dir_q;
   assign out_dir   = out_dir_q;
   // direction bit travels with the result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_dir_q <= 1'b0;
      else     out_dir_q <= out_dir_d;
   end
`else
   assign sel_dir = 1'b0;
`endif
   // load on transfer, clear on drain-only, otherwise hold
   always_comb begin
      out_valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      out_data_d  = xfer ? rotate(req_data[int'(gnt_id)*DATA_W +: DATA_W], req_amt[int'(gnt_id)*AMT_W +: AMT_W], sel_dir) : out_data_q;
      out_id_d    = xfer ? gnt_id : out_id_q;
      last_id_d   = xfer ? gnt_id : last_id_q;
   end
   // output register and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         last_id_q   <= ID_W'(NUM_REQ - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         last_id_q   <= last_id_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed checks of arbitration, rotation, stall and reset for shift_arbiter
module tb_shift_arbiter;
   logic        clk, rst, out_valid, out_ready;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_data;
   logic [11:0] req_amt;
   logic [7:0]  out_data;
   logic [1:0]  out_id;
   int          total = 0, bad = 0;
`ifdef SHIFT_ARB_DIR_EN
   logic [3:0]  req_dir;
   logic        out_dir;
`endif
   shift_arbiter #(.NUM_REQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_amt   (req_amt),
`ifdef SHIFT_ARB_DIR_EN
      .req_dir   (req_dir),
      .out_dir   (out_dir),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic [2:0] a);
      req_valid[i]     = v;
      req_data[8*i+:8] = d;
      req_amt[3*i+:3]  = a;
   endtask
   initial begin
      logic [7:0] exp_rot [4];
      exp_rot = '{8'h81, 8'hC0, 8'h60, 8'h30};
      rst       = 1'b1;
      req_valid = 4'b0001;
      req_data  = '0;
      req_amt   = '0;
      out_ready = 1'b1;
`ifdef SHIFT_ARB_DIR_EN
      req_dir   = '0;
`endif
      #2;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'h00);
      chk("rst_id", 32'(out_id), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1'b1, 8'hB4, 3'd3);
      #1 chk("single_ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'h96);
      chk("single_id", 32'(out_id), 32'd0);
      req_valid = '0;
      @(negedge clk);
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_hold", 32'(out_data), 32'h96);
      rst = 1'b1;
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h81, 3'(i));
      for (int c = 0; c < 8; c++) begin
         #1 chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
         @(negedge clk);
         chk("rr_valid", 32'(out_valid), 32'd1);
         chk("rr_id", 32'(out_id), 32'(c % 4));
         chk("rr_data", 32'(out_data), 32'(exp_rot[c % 4]));
      end
      out_ready = 1'b0;
      req_valid = '0;
      set_req(2, 1'b1, 8'hA5, 3'd4);
      for (int c = 0; c < 5; c++) begin
         #1 chk("stall_ready", 32'(req_ready), 32'd0);
         chk("stall_data", 32'(out_data), 32'h30);
         chk("stall_id", 32'(out_id), 32'd3);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("unstall_ready", 32'(req_ready), 32'b0100);
      @(negedge clk);
      chk("amt4_data", 32'(out_data), 32'h5A);
      chk("amt4_id", 32'(out_id), 32'd2);
      req_valid = '0;
      set_req(1, 1'b1, 8'h81, 3'd0);
      @(negedge clk);
      chk("amt0_data", 32'(out_data), 32'h81);
      set_req(1, 1'b1, 8'h81, 3'd7);
      @(negedge clk);
      chk("amt7_data", 32'(out_data), 32'h03);
      chk("amt7_id", 32'(out_id), 32'd1);
      req_valid = '0;
      out_ready = 1'b0;
      set_req(0, 1'b1, 8'h01, 3'd0);
      set_req(3, 1'b1, 8'hFF, 3'd0);
      #1 chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_ready", 32'(req_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("post_rst_ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      chk("post_rst_id", 32'(out_id), 32'd0);
      chk("post_rst_data", 32'(out_data), 32'h01);
`ifdef SHIFT_ARB_DIR_EN
      req_valid = '0;
      req_dir   = 4'b0010;
      set_req(1, 1'b1, 8'h81, 3'd1);
      @(negedge clk);
      chk("left1_data", 32'(out_data), 32'h03);
      chk("left1_dir", 32'(out_dir), 32'd1);
      set_req(1, 1'b1, 8'h81, 3'd0);
      @(negedge clk);
      chk("left0_data", 32'(out_data), 32'h81);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
